// File: rtl/dsi_pkt_sched.sv
// ---------------------------------------------------------------------------
// dsi_pkt_sched
//
// Schedules HS packet transmission on the single nano-DSI data lane between
// two FIFO-style packet sources: src0 (SPI command FIFO) and src1
// (pixel/refresh streamer). Packets are atomic once granted. The block also
// owns the HS clock-lane request (raised while traffic is pending, released
// after an idle timeout) and enforces a programmable inter-packet gap.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   srcN_valid         source N has a complete packet available
//   srcN_data/last     current byte of source N and its end-of-packet flag
//   srcN_ack           read strobe to source N (consume current byte)
//   hs_start           packet start request to the data lane
//   hs_data/hs_last    byte and last-byte flag to the data lane
//   hs_ack             data lane consumed hs_data
//   hs_rdy             data lane idle (LP-11)
//   clk_req            HS clock lane request (registered)
//   clk_rdy            HS clock lane running
//   cfg_force_clk      hold clk_req high unconditionally
//   cfg_gap            minimum idle cycles between packets
//   grant              one-hot current owner, 00 when none
//   busy               scheduler is not in IDLE
// ---------------------------------------------------------------------------
module dsi_pkt_sched #(
  parameter int IDLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       src0_valid,
  input  logic [7:0] src0_data,
  input  logic       src0_last,
  output logic       src0_ack,
  input  logic       src1_valid,
  input  logic [7:0] src1_data,
  input  logic       src1_last,
  output logic       src1_ack,
  output logic       hs_start,
  output logic [7:0] hs_data,
  output logic       hs_last,
  input  logic       hs_ack,
  input  logic       hs_rdy,
  output logic       clk_req,
  input  logic       clk_rdy,
  input  logic       cfg_force_clk,
  input  logic [7:0] cfg_gap,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAKE,
    ARB,
    XFER,
    GAP
  } state_t;

  localparam logic [15:0] IDLE_MAX = 16'(IDLE_CYCLES);

  state_t      state;
  logic [15:0] idle_cnt;
  logic [7:0]  gap_cnt;
  logic        last_served;  // 0: src0 served last, 1: src1 served last

  logic any_valid;
  logic lane_ready;
  logic req_set;

  assign any_valid  = src0_valid | src1_valid;
  assign lane_ready = clk_rdy & hs_rdy;
  // Anything that means the clock lane is (or is about to be) needed.
  assign req_set    = any_valid | cfg_force_clk | (state != IDLE);

  // Data path is a plain mux on the registered grant, so the lane sees the
  // owning source's byte with no extra latency.
  assign hs_data  = grant[0] ? src0_data : (grant[1] ? src1_data : 8'd0);
  assign hs_last  = grant[0] ? src0_last : (grant[1] ? src1_last : 1'b0);
  assign src0_ack = hs_ack & grant[0];
  assign src1_ack = hs_ack & grant[1];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 2'b00;
      hs_start    <= 1'b0;
      clk_req     <= 1'b0;
      idle_cnt    <= 16'd0;
      gap_cnt     <= 8'd0;
      last_served <= 1'b1;
    end else begin
      // Clock-lane request: the set term always beats the timeout, so a
      // valid arriving on the expiry cycle keeps the lane running.
      if (req_set) begin
        clk_req  <= 1'b1;
        idle_cnt <= 16'd0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 16'd1;
      end else begin
        clk_req <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (any_valid) begin
            state <= lane_ready ? ARB : WAKE;
          end
        end

        WAKE: begin
          if (lane_ready) begin
            state <= ARB;
          end
        end

        // Round-robin on ties: prefer the source that was not served last.
        ARB: begin
          if (src0_valid && (!src1_valid || last_served)) begin
            grant       <= 2'b01;
            last_served <= 1'b0;
            hs_start    <= 1'b1;
            state       <= XFER;
          end else if (src1_valid) begin
            grant       <= 2'b10;
            last_served <= 1'b1;
            hs_start    <= 1'b1;
            state       <= XFER;
          end else begin
            state <= IDLE;
          end
        end

        // Packet is atomic: source valids are not looked at here, and
        // clk_rdy dropping is ignored until the packet and gap are done.
        XFER: begin
          if (hs_ack) begin
            hs_start <= 1'b0;
            if (hs_last) begin
              grant   <= 2'b00;
              gap_cnt <= cfg_gap;
              state   <= GAP;
            end
          end
        end

        GAP: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end
          if ((gap_cnt == 8'd0) && hs_rdy) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
